interrupt_controller: RTL and testbench

Parametrised vectored interrupt controller between N peripheral interrupt sources and the CPU core, replacing the fixed four-line interrupt inputs and clear outputs with edge-latched pending bits, a software-visible mask, fixed priority, per-source vectors and in-service tracking. It sits beside the CPU control unit. The CPU takes an interrupt through a request/acknowledge handshake and signals interrupt return with a pulse. Mask and status registers are mapped onto the data memory/IO bus.

---
 rtl/intc_pkg.sv | 16 +
 rtl/intc_prio_enc.sv | 22 ++
 rtl/interrupt_controller.sv | 124 ++++++++++++
 tb/tb_interrupt_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared constants for the vectored interrupt controller: register offsets,
// source-count limit and default vector layout.
package intc_pkg;

  localparam logic [1:0] INTC_MASK      = 2'd0;
  localparam logic [1:0] INTC_PENDING   = 2'd1;
  localparam logic [1:0] INTC_INSERVICE = 2'd2;
  localparam logic [1:0] INTC_STATUS    = 2'd3;

  localparam int unsigned INTC_MAX_IRQ = 8;
  localparam int unsigned INTC_IDX_W   = 3;

  localparam logic [15:0] INTC_VECTOR_BASE   = 16'h0008;
  localparam logic [15:0] INTC_VECTOR_STRIDE = 16'd4;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder; index is 0 when nothing is requesting.
module intc_prio_enc #(
  parameter int unsigned Width = 8,
  parameter int unsigned IdxW  = 3
) (
  input  logic [Width-1:0] req_i,
  output logic             found_o,
  output logic [IdxW-1:0]  index_o
);

  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int i = 0; i < int'(Width); i++) begin
      if (req_i[i] && !found_o) begin
        found_o = 1'b1;
        index_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Vectored interrupt controller: edge-latched pending bits, mask, fixed priority,
// in-service tracking. Define INTR_NESTING_EN to allow higher-priority preemption.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int unsigned NUM_IRQ       = 8,
  parameter logic [15:0] VECTOR_BASE   = INTC_VECTOR_BASE,
  parameter logic [15:0] VECTOR_STRIDE = INTC_VECTOR_STRIDE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic [NUM_IRQ-1:0] irq_clr,
  input  logic               int_enable,
  output logic               irq_req,
  output logic [15:0]        irq_vector,
  input  logic               irq_ack,
  input  logic               irq_reti,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  input  logic               reg_we,
  output logic [7:0]         reg_rdata
);

  logic [NUM_IRQ-1:0] src_q, pending_q, pending_d, mask_q, mask_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d, irq_clr_q, irq_clr_d;
  logic [NUM_IRQ-1:0] rise, eligible, win_oh, isr_oh, clr_mask;
  logic               win_found, isr_found, req_ok, ack_take;
  logic [INTC_IDX_W-1:0] win_idx, isr_idx;

  assign rise     = irq_src & ~src_q;
  assign eligible = pending_q & mask_q;

  intc_prio_enc #(
    .Width (NUM_IRQ),
    .IdxW  (INTC_IDX_W)
  ) u_win_enc (
    .req_i   (eligible),
    .found_o (win_found),
    .index_o (win_idx)
  );

  intc_prio_enc #(
    .Width (NUM_IRQ),
    .IdxW  (INTC_IDX_W)
  ) u_isr_enc (
    .req_i   (in_service_q),
    .found_o (isr_found),
    .index_o (isr_idx)
  );

  always_comb begin
    win_oh = '0;
    isr_oh = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      win_oh[i] = (win_idx == INTC_IDX_W'(i));
      isr_oh[i] = isr_found && (isr_idx == INTC_IDX_W'(i));
    end
  end

`ifdef INTR_NESTING_EN
  assign req_ok = !isr_found || (win_idx < isr_idx);
`else
  assign req_ok = !isr_found;
`endif

  assign irq_req    = int_enable && win_found && req_ok;
  assign irq_vector = irq_req ? VECTOR_BASE + 16'(win_idx) * VECTOR_STRIDE : VECTOR_BASE;
  assign ack_take   = irq_ack && irq_req;
  assign irq_clr    = irq_clr_q;

  always_comb begin
    clr_mask = ack_take ? win_oh : '0;
    if (reg_we && reg_addr == INTC_PENDING) begin
      clr_mask = clr_mask | reg_wdata[NUM_IRQ-1:0];
    end
    // A fresh edge beats any clear of the same bit.
    pending_d = (pending_q & ~clr_mask) | rise;

    mask_d = mask_q;
    if (reg_we && reg_addr == INTC_MASK) begin
      mask_d = reg_wdata[NUM_IRQ-1:0];
    end

    // Without nesting at most one bit is set, so popping the top bit clears all.
    in_service_d = in_service_q;
    if (irq_reti) begin
      in_service_d = in_service_d & ~isr_oh;
    end
    if (ack_take) begin
      in_service_d = in_service_d | win_oh;
    end

    irq_clr_d = ack_take ? win_oh : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      in_service_q <= '0;
      irq_clr_q    <= '0;
    end else begin
      src_q        <= irq_src;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      irq_clr_q    <= irq_clr_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      INTC_MASK:      reg_rdata[NUM_IRQ-1:0] = mask_q;
      INTC_PENDING:   reg_rdata[NUM_IRQ-1:0] = pending_q;
      INTC_INSERVICE: reg_rdata[NUM_IRQ-1:0] = in_service_q;
      INTC_STATUS:    reg_rdata = {irq_req, 4'b0, win_idx};
      default:        reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Table-driven bench for interrupt_controller plus hand sequences for nesting
// and reset during an acknowledge.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic [7:0]  irq_clr;
  logic        int_enable;
  logic        irq_req;
  logic [15:0] irq_vector;
  logic        irq_ack;
  logic        irq_reti;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic [7:0]  reg_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .irq_clr    (irq_clr),
    .int_enable (int_enable),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .irq_ack    (irq_ack),
    .irq_reti   (irq_reti),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_rdata  (reg_rdata)
  );

  typedef struct {
    logic [7:0]  src;
    logic        en;
    logic        we;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic        ack;
    logic        reti;
    logic        exp_req;
    logic [15:0] exp_vec;
    logic [7:0]  exp_clr;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [7:0] s, input logic e, input logic w,
                       input logic [1:0] a, input logic [7:0] d,
                       input logic k, input logic r);
    @(negedge clk);
    irq_src = s; int_enable = e; reg_we = w; reg_addr = a;
    reg_wdata = d; irq_ack = k; irq_reti = r;
    #1;
  endtask

  task automatic row(input logic [7:0] s, input logic e, input logic w, input logic [1:0] a,
                     input logic [7:0] d, input logic k, input logic r, input logic rq,
                     input logic [15:0] v, input logic [7:0] c, input logic [7:0] rd);
    tbl.push_back('{s, e, w, a, d, k, r, rq, v, c, rd});
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; int_enable = 1'b0; irq_ack = 1'b0; irq_reti = 1'b0;
    reg_addr = '0; reg_wdata = '0; reg_we = 1'b0;

    //  src  en we ad wdat ak rt | req vec     clr    rdata
    row(8'h00, 1, 1, 0, 8'hFF, 0, 0, 0, 16'h0008, 8'h00, 8'h00);
    row(8'h08, 1, 0, 0, 8'h00, 0, 0, 0, 16'h0008, 8'h00, 8'hFF);
    row(8'h08, 1, 0, 3, 8'h00, 0, 0, 1, 16'h0014, 8'h00, 8'h83);
    row(8'h00, 1, 0, 1, 8'h00, 1, 0, 1, 16'h0014, 8'h00, 8'h08);
    row(8'h00, 1, 0, 2, 8'h00, 0, 0, 0, 16'h0008, 8'h08, 8'h08);
    row(8'h00, 1, 0, 2, 8'h00, 0, 1, 0, 16'h0008, 8'h00, 8'h08);
    row(8'h22, 1, 0, 2, 8'h00, 0, 0, 0, 16'h0008, 8'h00, 8'h00);
    row(8'h00, 1, 0, 1, 8'h00, 1, 0, 1, 16'h000C, 8'h00, 8'h22);
    row(8'h00, 1, 0, 3, 8'h00, 0, 0, 0, 16'h0008, 8'h02, 8'h05);
    row(8'h00, 1, 0, 2, 8'h00, 0, 1, 0, 16'h0008, 8'h00, 8'h02);
    row(8'h00, 1, 0, 3, 8'h00, 1, 0, 1, 16'h001C, 8'h00, 8'h85);
    row(8'h00, 1, 0, 2, 8'h00, 0, 1, 0, 16'h0008, 8'h20, 8'h20);
    row(8'h00, 1, 0, 2, 8'h00, 1, 0, 0, 16'h0008, 8'h00, 8'h00);
    row(8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 16'h0008, 8'h00, 8'hFF);
    row(8'h04, 1, 0, 0, 8'h00, 0, 0, 0, 16'h0008, 8'h00, 8'h00);
    row(8'h00, 1, 0, 1, 8'h00, 0, 0, 0, 16'h0008, 8'h00, 8'h04);
    row(8'h00, 1, 1, 0, 8'h04, 0, 0, 0, 16'h0008, 8'h00, 8'h00);
    row(8'h00, 1, 0, 3, 8'h00, 0, 0, 1, 16'h0010, 8'h00, 8'h82);
    row(8'h00, 1, 1, 1, 8'h04, 0, 0, 1, 16'h0010, 8'h00, 8'h04);
    row(8'h00, 1, 0, 1, 8'h00, 0, 0, 0, 16'h0008, 8'h00, 8'h00);
    row(8'h04, 1, 0, 1, 8'h00, 0, 0, 0, 16'h0008, 8'h00, 8'h00);
    row(8'h00, 1, 0, 1, 8'h00, 0, 0, 1, 16'h0010, 8'h00, 8'h04);
    row(8'h04, 1, 1, 1, 8'h04, 0, 0, 1, 16'h0010, 8'h00, 8'h04);
    row(8'h04, 1, 0, 1, 8'h00, 0, 0, 1, 16'h0010, 8'h00, 8'h04);
    row(8'h04, 1, 0, 1, 8'h00, 1, 0, 1, 16'h0010, 8'h00, 8'h04);
    row(8'h04, 1, 0, 1, 8'h00, 0, 0, 0, 16'h0008, 8'h04, 8'h00);
    row(8'h00, 1, 0, 2, 8'h00, 0, 1, 0, 16'h0008, 8'h00, 8'h04);
    row(8'h04, 1, 0, 1, 8'h00, 0, 0, 0, 16'h0008, 8'h00, 8'h00);
    row(8'h00, 1, 0, 1, 8'h00, 0, 0, 1, 16'h0010, 8'h00, 8'h04);
    row(8'h04, 1, 0, 1, 8'h00, 1, 0, 1, 16'h0010, 8'h00, 8'h04);
    row(8'h04, 1, 0, 1, 8'h00, 0, 0, 0, 16'h0008, 8'h04, 8'h04);
    row(8'h04, 1, 0, 2, 8'h00, 0, 1, 0, 16'h0008, 8'h00, 8'h04);
    row(8'h04, 0, 0, 1, 8'h00, 0, 0, 0, 16'h0008, 8'h00, 8'h04);
    row(8'h04, 1, 0, 1, 8'h00, 0, 0, 1, 16'h0010, 8'h00, 8'h04);
    row(8'h04, 1, 0, 2, 8'h00, 1, 0, 1, 16'h0010, 8'h00, 8'h00);
    row(8'h00, 1, 0, 2, 8'h00, 0, 1, 0, 16'h0008, 8'h04, 8'h04);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 16'(irq_req), 16'h0);
    chk("rst_vec", irq_vector, 16'h0008);
    chk("rst_clr", 16'(irq_clr), 16'h0);
    for (int a = 0; a < 3; a++) begin
      reg_addr = 2'(a);
      #1;
      chk($sformatf("rst_reg%0d", a), 16'(reg_rdata), 16'h0);
    end
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].src, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ack, tbl[i].reti);
      chk($sformatf("row%0d_req", i), 16'(irq_req), 16'(tbl[i].exp_req));
      chk($sformatf("row%0d_vec", i), irq_vector, tbl[i].exp_vec);
      chk($sformatf("row%0d_clr", i), 16'(irq_clr), 16'(tbl[i].exp_clr));
      chk($sformatf("row%0d_rd", i), 16'(reg_rdata), 16'(tbl[i].exp_rd));
    end

    // Source 4 in service, then source 0 rises
    drive(8'h00, 1, 1, 0, 8'hFF, 0, 0);
    drive(8'h10, 1, 0, 2, 8'h00, 0, 0);
    drive(8'h00, 1, 0, 2, 8'h00, 1, 0);
    chk("nest_req4", 16'(irq_req), 16'h1);
    chk("nest_vec4", irq_vector, 16'h0018);
    drive(8'h01, 1, 0, 2, 8'h00, 0, 0);
    chk("nest_isr4", 16'(reg_rdata), 16'h10);
    drive(8'h00, 1, 0, 2, 8'h00, 0, 0);
`ifdef INTR_NESTING_EN
    chk("nest_req0", 16'(irq_req), 16'h1);
    chk("nest_vec0", irq_vector, 16'h0008);
    drive(8'h00, 1, 0, 2, 8'h00, 1, 0);
    drive(8'h00, 1, 0, 2, 8'h00, 0, 0);
    chk("nest_isr11", 16'(reg_rdata), 16'h11);
    drive(8'h00, 1, 0, 2, 8'h00, 0, 1);
    drive(8'h00, 1, 0, 2, 8'h00, 0, 0);
    chk("nest_pop0", 16'(reg_rdata), 16'h10);
    drive(8'h00, 1, 0, 2, 8'h00, 0, 1);
    drive(8'h00, 1, 0, 2, 8'h00, 0, 0);
    chk("nest_pop4", 16'(reg_rdata), 16'h00);
`else
    chk("nonest_req0", 16'(irq_req), 16'h0);
    drive(8'h00, 1, 0, 2, 8'h00, 0, 1);
    chk("nonest_held", 16'(irq_req), 16'h0);
    drive(8'h00, 1, 0, 2, 8'h00, 0, 0);
    chk("nonest_req_after", 16'(irq_req), 16'h1);
    chk("nonest_vec_after", irq_vector, 16'h0008);
    chk("nonest_isr_clear", 16'(reg_rdata), 16'h00);
    drive(8'h00, 1, 0, 2, 8'h00, 1, 0);
    drive(8'h00, 1, 0, 2, 8'h00, 0, 1);
    chk("nonest_isr1", 16'(reg_rdata), 16'h01);
    drive(8'h00, 1, 0, 2, 8'h00, 0, 0);
    chk("nonest_isr_end", 16'(reg_rdata), 16'h00);
`endif

    // Reset asserted in the cycle after an acknowledge
    drive(8'h08, 1, 0, 0, 8'h00, 0, 0);
    drive(8'h00, 1, 0, 0, 8'h00, 1, 0);
    chk("hs_req", 16'(irq_req), 16'h1);
    chk("hs_vec", irq_vector, 16'h0014);
    @(posedge clk);
    #1;
    chk("hs_clr_pulse", 16'(irq_clr), 16'h08);
    irq_ack = 1'b0;
    reset = 1'b1;
    #1;
    chk("hs_rst_clr", 16'(irq_clr), 16'h0);
    chk("hs_rst_req", 16'(irq_req), 16'h0);
    chk("hs_rst_vec", irq_vector, 16'h0008);
    for (int a = 0; a < 3; a++) begin
      reg_addr = 2'(a);
      #1;
      chk($sformatf("hs_rst_reg%0d", a), 16'(reg_rdata), 16'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(8'h00, 1, 0, 2, 8'h00, 0, 0);
    chk("hs_post_clr", 16'(irq_clr), 16'h0);
    chk("hs_post_isr", 16'(reg_rdata), 16'h0);
    chk("hs_post_req", 16'(irq_req), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
